// File: rtl/alu_seq_m.sv
// Execute-stage ALU with handshaked input/output and registered results.
// Base ops complete one cycle after accept. RV32M ops run an iterative
// 1 bit/cycle multiplier or restoring divider on operand magnitudes,
// with the sign fix-up applied on the last iteration.
//
// state  | meaning
// IDLE   | ready for a new request
// EXEC   | decode latched op: base result written, or mul/div datapath loaded
// MUL    | shift-add multiply, XLEN iterations
// DIV    | restoring divide, XLEN iterations
// DONE   | result valid, held until out_ready
module alu_seq_m #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_DIV, S_DONE} state_t;

    state_t               state_q;
    logic [4:0]           op_q;
    logic [XLEN-1:0]      a_q, b_q;
    logic [XLEN-1:0]      hi_q, lo_q, mag_q;
    logic                 neg_q;
    logic [SHAMT_W-1:0]   cnt_q;
    logic [XLEN-1:0]      result_q;
    logic                 zero_q;

    logic [XLEN-1:0]      base_res;
    logic [SHAMT_W-1:0]   shamt;
    logic [2:0]           f3;
    logic                 is_div, a_signed, b_signed, sa, sb, neg_d;
    logic [XLEN-1:0]      ma, mb;
    logic [XLEN:0]        mul_sum;
    logic [XLEN-1:0]      mul_hi_n, mul_lo_n, mul_res;
    logic [2*XLEN-1:0]    prod, prod_f;
    logic [XLEN:0]        rem_sh, diff;
    logic                 ge;
    logic [XLEN-1:0]      div_hi_n, div_lo_n, div_sel, div_res;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
    assign result    = result_q;
    assign zero      = zero_q;

    // Base ALU on the latched operands; only the low SHAMT_W bits of b shift.
    always_comb begin
        shamt    = b_q[SHAMT_W-1:0];
        base_res = '0;
        case (op_q[3:0])
            4'd0: base_res = a_q + b_q;
            4'd1: base_res = a_q - b_q;
            4'd2: base_res = a_q ^ b_q;
            4'd3: base_res = a_q | b_q;
            4'd4: base_res = a_q & b_q;
            4'd5: base_res = a_q << shamt;
            4'd6: base_res = a_q >> shamt;
            4'd7: base_res = XLEN'($signed(a_q) >>> shamt);
            4'd8: base_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            4'd9: base_res = {{(XLEN-1){1'b0}}, (a_q < b_q)};
            default: base_res = '0;
        endcase
    end

    // Operand signedness, magnitudes and the final negate flag for M ops.
    // A divide by zero keeps the all-ones quotient unsigned-looking, so its
    // quotient is never negated.
    always_comb begin
        f3       = op_q[2:0];
        is_div   = f3[2];
        a_signed = is_div ? ~f3[0] : ((f3 == 3'd1) || (f3 == 3'd2));
        b_signed = is_div ? ~f3[0] : (f3 == 3'd1);
        sa       = a_signed & a_q[XLEN-1];
        sb       = b_signed & b_q[XLEN-1];
        ma       = sa ? -a_q : a_q;
        mb       = sb ? -b_q : b_q;
        if (is_div)
            neg_d = f3[1] ? sa : ((sa ^ sb) & (b_q != '0));
        else
            neg_d = sa ^ sb;
    end

    // One shift-add multiply step plus the signed fix-up of the full product.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
        mul_hi_n = mul_sum[XLEN:1];
        mul_lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
        prod     = {mul_hi_n, mul_lo_n};
        prod_f   = neg_q ? -prod : prod;
        mul_res  = (op_q[2:0] == 3'd0) ? prod_f[XLEN-1:0] : prod_f[2*XLEN-1:XLEN];
    end

    // One restoring divide step; hi holds the partial remainder, lo the quotient.
    always_comb begin
        rem_sh   = {hi_q, lo_q[XLEN-1]};
        diff     = rem_sh - {1'b0, mag_q};
        ge       = ~diff[XLEN];
        div_hi_n = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        div_lo_n = {lo_q[XLEN-2:0], ge};
        div_sel  = op_q[1] ? div_hi_n : div_lo_n;
        div_res  = neg_q ? -div_sel : div_sel;
    end

    // Sequencer and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mag_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q    <= op;
                        a_q     <= a;
                        b_q     <= b;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    cnt_q <= '0;
                    neg_q <= neg_d;
                    hi_q  <= '0;
                    if (!op_q[4]) begin
                        result_q <= base_res;
                        zero_q   <= (base_res == '0);
                        state_q  <= S_DONE;
                    end else if (is_div) begin
                        lo_q    <= ma;
                        mag_q   <= mb;
                        state_q <= S_DIV;
                    end else begin
                        lo_q    <= mb;
                        mag_q   <= ma;
                        state_q <= S_MUL;
                    end
                end
                S_MUL: begin
                    hi_q  <= mul_hi_n;
                    lo_q  <= mul_lo_n;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == SHAMT_W'(XLEN-1)) begin
                        cnt_q    <= '0;
                        result_q <= mul_res;
                        zero_q   <= (mul_res == '0);
                        state_q  <= S_DONE;
                    end
                end
                S_DIV: begin
                    hi_q  <= div_hi_n;
                    lo_q  <= div_lo_n;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == SHAMT_W'(XLEN-1)) begin
                        cnt_q    <= '0;
                        result_q <= div_res;
                        zero_q   <= (div_res == '0);
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_m.sv
// Directed bench for alu_seq_m: hand-computed vectors for base and M ops,
// latency, backpressure, held in_valid, and mid-divide reset.
module tb_alu_seq_m;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [4:0] OP_ADD  = 5'h00, OP_SUB  = 5'h01, OP_SLL   = 5'h05,
                           OP_SRL  = 5'h06, OP_SRA  = 5'h07, OP_SLT   = 5'h08,
                           OP_SLTU = 5'h09, OP_RSV  = 5'h0C,
                           OP_MUL  = 5'h10, OP_MULH = 5'h11, OP_MULHSU = 5'h12,
                           OP_MULHU = 5'h13, OP_DIV = 5'h14, OP_DIVU  = 5'h15,
                           OP_REM  = 5'h16, OP_REMU = 5'h17;

    alu_seq_m #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, measure accept-to-out_valid latency and busy cycles, check, then release.
    task automatic run_op(input string tag, input logic [4:0] op_v, input logic [31:0] a_v,
                          input logic [31:0] b_v, input logic [31:0] exp_v, input int exp_lat);
        int lat;
        int busy_cnt;
        @(negedge clk);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        op = op_v;
        a = a_v;
        b = b_v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!out_valid && lat < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        if (exp_lat > 1)
            chk({tag, ".busy"}, 32'(busy_cnt), 32'(exp_lat - 1));
        chk({tag, ".res"}, result, exp_v);
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, (exp_v == 32'd0)});
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".ready_after"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.result", result, 32'd0);
        chk("rst.zero", {31'd0, zero}, 32'd1);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("add",    OP_ADD,  32'd5,          32'd7,          32'd12,         1);
        run_op("sub",    OP_SUB,  32'h1234,       32'h1234,       32'd0,          1);
        run_op("sra",    OP_SRA,  32'h8000_0000,  32'd4,          32'hF800_0000,  1);
        run_op("srl",    OP_SRL,  32'h8000_0000,  32'd4,          32'h0800_0000,  1);
        run_op("slt",    OP_SLT,  32'hFFFF_FFFF,  32'd1,          32'd1,          1);
        run_op("sltu",   OP_SLTU, 32'hFFFF_FFFF,  32'd1,          32'd0,          1);
        run_op("sll",    OP_SLL,  32'd1,          32'd35,         32'd8,          1);
        run_op("rsv",    OP_RSV,  32'd9,          32'd9,          32'd0,          1);

        run_op("mul",    OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
        run_op("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulh",   OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);

        run_op("div",    OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 33);
        run_op("rem",    OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 33);
        run_op("divu0",  OP_DIVU, 32'd7,          32'd0,          32'hFFFF_FFFF, 33);
        run_op("remu0",  OP_REMU, 32'd7,          32'd0,          32'd7,         33);
        run_op("div0s",  OP_DIV,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF, 33);
        run_op("rem0s",  OP_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9, 33);
        run_op("divov",  OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 33);
        run_op("remov",  OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,         33);
        run_op("divu",   OP_DIVU, 32'd100,        32'd7,          32'd14,        33);
        run_op("remu",   OP_REMU, 32'd100,        32'd7,          32'd2,         33);

        // Backpressure on a mul (3*5), with a new add request held high throughout.
        begin
            int lat;
            @(negedge clk);
            in_valid = 1'b1;
            op = OP_MUL;
            a = 32'd3;
            b = 32'd5;
            @(posedge clk);
            #1;
            op = OP_ADD;
            a = 32'd1;
            b = 32'd2;
            lat = 0;
            while (!out_valid && lat < 100) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk("bp.lat", 32'(lat), 32'd33);
            for (int i = 0; i < 10; i++) begin
                chk("bp.res", result, 32'd15);
                chk("bp.zero", {31'd0, zero}, 32'd0);
                chk("bp.ovalid", {31'd0, out_valid}, 32'd1);
                chk("bp.iready", {31'd0, in_ready}, 32'd0);
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            chk("bp.iready_rel", {31'd0, in_ready}, 32'd1);
            chk("bp.ovalid_rel", {31'd0, out_valid}, 32'd0);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("held.accept", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
            chk("held.ovalid", {31'd0, out_valid}, 32'd1);
            chk("held.res", result, 32'd3);
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end

        // Reset during iteration 15 of a divide.
        @(negedge clk);
        in_valid = 1'b1;
        op = OP_DIV;
        a = 32'd1000;
        b = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        chk("rstdiv.busy_pre", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rstdiv.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rstdiv.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rstdiv.result", result, 32'd0);
        chk("rstdiv.busy", {31'd0, busy}, 32'd0);
        run_op("add_post", OP_ADD, 32'd1, 32'd1, 32'd2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
